// File: rtl/halut_encoder_pkg.sv
// Shared types and sizing for the HALUT decision-tree encoder.
//   TreeDepth : default number of tree levels (leaf index width)
//   FpWidth   : width of one FP16 feature / threshold word
//   NumNodes  : internal node count of the balanced tree (2**TreeDepth - 1)
//   fp16_t    : raw FP16 bit pattern
//   enc_state_e : encoder FSM states
package halut_encoder_pkg;

  localparam int unsigned TreeDepth = 4;
  localparam int unsigned FpWidth   = 16;
  localparam int unsigned NumNodes  = (1 << TreeDepth) - 1;

  typedef logic [FpWidth-1:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/fp_16_comparision.sv
// FP16 strict greater-than comparator (combinational).
//   operand_a     : FP16 left operand
//   operand_b     : FP16 right operand
//   comparision_o : 1 when operand_a > operand_b
// Pure sign-magnitude ordering: +0 > -0, NaN/Inf are ordered by their
// bit patterns like any other value.
module fp_16_comparision (
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  output logic        comparision_o
);

  always_comb begin
    comparision_o = 1'b0;
    if (operand_a[15] != operand_b[15]) begin
      comparision_o = ~operand_a[15];
    end else if (!operand_a[15]) begin
      comparision_o = (operand_a[14:0] > operand_b[14:0]);
    end else begin
      // both negative: larger magnitude is the smaller value
      comparision_o = (operand_a[14:0] < operand_b[14:0]);
    end
  end

endmodule

// File: rtl/fp_16_tree_encoder.sv
// Decision-tree encoder: walks a balanced binary tree of depth TreeDepth,
// one level per cycle, using a single shared FP16 comparator, and emits
// the leaf (prototype) index.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o: feature vector handshake
//   in_feat_i            : TreeDepth FP16 features, slice l used at level l
//   out_valid_o/out_ready_i: leaf index handshake
//   out_idx_o            : leaf index (held while out_valid_o)
//   cfg_we_i/addr/data   : threshold register write port (IDLE only)
//   cfg_err_o            : one-cycle pulse after a rejected write
//   busy_o               : FSM not in IDLE
// Optional: define HALUT_ENC_TIE_RIGHT_EN to send exact ties right (a>=b).
module fp_16_tree_encoder #(
  parameter int unsigned TreeDepth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [TreeDepth*16-1:0] in_feat_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [TreeDepth-1:0]    out_idx_o,
  input  logic                    cfg_we_i,
  input  logic [TreeDepth-1:0]    cfg_addr_i,
  input  logic [15:0]             cfg_data_i,
  output logic                    cfg_err_o,
  output logic                    busy_o
);

  import halut_encoder_pkg::*;

  localparam int unsigned NodeCnt = (1 << TreeDepth) - 1;
  localparam int unsigned LevelW  = (TreeDepth > 1) ? $clog2(TreeDepth) : 1;

  enc_state_e            state_q, state_d;
  fp16_t                 feat_q [TreeDepth];
  fp16_t                 feat_d [TreeDepth];
  fp16_t                 thr_q  [NodeCnt];
  fp16_t                 thr_d  [NodeCnt];
  logic [TreeDepth:0]    node_q, node_d;
  logic [LevelW-1:0]     level_q, level_d;
  logic [TreeDepth-1:0]  idx_q, idx_d;
  logic                  cfg_err_q, cfg_err_d;

  fp16_t                 cmp_a, cmp_b;
  logic                  cmp_gt;
  logic                  dir;
  logic [TreeDepth:0]    node_nxt;
  logic                  addr_ok;

  // Outside WALK node_q is parked at 0, so this index is always in range.
  assign cmp_a = feat_q[level_q];
  assign cmp_b = thr_q[node_q[TreeDepth-1:0]];

  fp_16_comparision u_cmp (
    .operand_a    (cmp_a),
    .operand_b    (cmp_b),
    .comparision_o(cmp_gt)
  );

`ifdef HALUT_ENC_TIE_RIGHT_EN
  assign dir = cmp_gt | (cmp_a == cmp_b);
`else
  assign dir = cmp_gt;
`endif

  assign node_nxt = (node_q << 1) + (TreeDepth+1)'(1) + (TreeDepth+1)'(dir);

  // NodeCnt is all-ones in TreeDepth bits, so only the all-ones address is out of range.
  assign addr_ok = (cfg_addr_i != '1);

  always_comb begin
    state_d   = state_q;
    feat_d    = feat_q;
    thr_d     = thr_q;
    node_d    = node_q;
    level_d   = level_q;
    idx_d     = idx_q;
    cfg_err_d = 1'b0;

    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;

    if (cfg_we_i) begin
      if ((state_q == IDLE) && addr_ok) begin
        thr_d[cfg_addr_i] = cfg_data_i;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) begin
          for (int unsigned l = 0; l < TreeDepth; l++) begin
            feat_d[l] = in_feat_i[16*l +: 16];
          end
          node_d  = '0;
          level_d = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (level_q == LevelW'(TreeDepth - 1)) begin
          // leaf = final node - NodeCnt, truncated to TreeDepth bits
          idx_d   = node_nxt[TreeDepth-1:0] - TreeDepth'(NodeCnt);
          node_d  = '0;
          level_d = '0;
          state_d = DONE;
        end else begin
          node_d  = node_nxt;
          level_d = level_q + LevelW'(1);
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      node_q    <= '0;
      level_q   <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int unsigned l = 0; l < TreeDepth; l++) begin
        feat_q[l] <= '0;
      end
      for (int unsigned n = 0; n < NodeCnt; n++) begin
        thr_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      feat_q    <= feat_d;
      thr_q     <= thr_d;
      node_q    <= node_d;
      level_q   <= level_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out_idx_o = idx_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_fp_16_tree_encoder.sv
module tb_fp_16_tree_encoder;

`ifdef HALUT_ENC_TIE_RIGHT_EN
  localparam logic [3:0] TieIdx = 4'hF;
`else
  localparam logic [3:0] TieIdx = 4'h0;
`endif

  logic        clk_i;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_feat_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_idx_o;
  logic        cfg_we_i;
  logic [3:0]  cfg_addr_i;
  logic [15:0] cfg_data_i;
  logic        cfg_err_o;
  logic        busy_o;

  int          n_vec;
  int          n_err;
  logic [3:0]  exp_q[$];

  fp_16_tree_encoder #(.TreeDepth(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_feat_i  (in_feat_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_idx_o  (out_idx_o),
    .cfg_we_i   (cfg_we_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_data_i (cfg_data_i),
    .cfg_err_o  (cfg_err_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: rejected cfg write during WALK; 2: cfg write thr[0]=4000 with accept
  task automatic encode(input logic [63:0] feat, input logic [3:0] exp,
                        input int mode, input int hold);
    int         cyc;
    logic [3:0] e;
    logic [3:0] held;
    exp_q.push_back(exp);
    out_ready_i = (hold == 0);
    in_feat_i   = feat;
    in_valid_i  = 1'b1;
    if (mode == 2) begin
      cfg_we_i   = 1'b1;
      cfg_addr_i = 4'd0;
      cfg_data_i = 16'h4000;
    end
    @(negedge clk_i);
    cyc        = 1;
    in_valid_i = 1'b0;
    cfg_we_i   = 1'b0;
    chk("accept_busy", busy_o, 1'b1);
    if (mode == 1) begin
      cfg_we_i   = 1'b1;
      cfg_addr_i = 4'd0;
      cfg_data_i = 16'h4000;
      @(negedge clk_i);
      cyc++;
      cfg_we_i = 1'b0;
      chk("walk_cfg_err_pulse", cfg_err_o, 1'b1);
      @(negedge clk_i);
      cyc++;
      chk("walk_cfg_err_clear", cfg_err_o, 1'b0);
    end
    while (!out_valid_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("out_valid_seen", out_valid_o, 1'b1);
    chk("latency", cyc, 5);
    e = exp_q.pop_front();
    chk("leaf_idx", out_idx_o, e);
    held = out_idx_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("bp_idx_stable", out_idx_o, held);
      chk("bp_valid_held", out_valid_o, 1'b1);
      chk("bp_in_ready_low", in_ready_o, 1'b0);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("release_valid", out_valid_o, 1'b0);
    chk("release_ready", in_ready_o, 1'b1);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data, input logic exp_err);
    cfg_we_i   = 1'b1;
    cfg_addr_i = addr;
    cfg_data_i = data;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    chk("cfg_err", cfg_err_o, exp_err);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_feat_i   = '0;
    out_ready_i = 1'b1;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_data_i  = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_idx", out_idx_o, 4'h0);
    chk("rst_cfg_err", cfg_err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    encode({4{16'h3C00}}, 4'hF, 0, 0);
    encode({4{16'hBC00}}, 4'h0, 0, 0);
    encode({16'hBC00, 16'h3C00, 16'hBC00, 16'h3C00}, 4'hA, 0, 0);
    encode({4{16'h3C00}}, 4'hF, 1, 0);
    encode({4{16'h3800}}, 4'hF, 0, 0);

    cfg_write(4'd15, 16'h1234, 1'b1);
    @(negedge clk_i);
    chk("addr15_err_clear", cfg_err_o, 1'b0);

    encode({4{16'h0000}}, TieIdx, 0, 0);
    encode({4{16'h8000}}, 4'h0, 0, 0);
    encode({4{16'h7E00}}, 4'hF, 0, 0);

    // thr[0]=2.0 written on the accept edge: 0 -> 1 -> 4 -> 10 -> 22, leaf 7
    encode({4{16'h3C00}}, 4'h7, 2, 0);

    for (int unsigned n = 0; n < 15; n++) begin
      cfg_write(4'(n), 16'h3C00, 1'b0);
    end
    encode({4{16'h3C00}}, TieIdx, 0, 0);
    encode({4{16'h4000}}, 4'hF, 0, 3);

    in_feat_i  = {4{16'h3800}};
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("midwalk_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid_o, 1'b0);
    chk("midrst_in_ready", in_ready_o, 1'b1);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_idx", out_idx_o, 4'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    encode({4{16'h3800}}, 4'hF, 0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
